// File: rtl/dypat.sv
// dypat: runtime-learned serial pattern detector. After reset the first PAT_W bits become the pattern.
// Latency: out is registered at the edge that samples the last bit of a match and is high for that cycle.
// No backpressure: one bit is consumed every cycle. Build option DYPAT_OVERLAP_EN flags overlapping matches.
module dypat #(
  parameter int PAT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int              CW   = $clog2(PAT_W + 1);
  localparam logic [CW-1:0]   LAST = CW'(PAT_W - 1);
  localparam logic [CW-1:0]   FULL = CW'(PAT_W);

  typedef enum logic {
    LEARN  = 1'b0,
    DETECT = 1'b1
  } phase_t;

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] w_pat_nxt;
  logic [PAT_W-1:0] r_shreg;
  logic [PAT_W-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_out;
  logic             w_out_nxt;
  logic [PAT_W-1:0] w_pat_shift;
  logic [PAT_W-1:0] w_win;
  logic             w_match;

  // Shift-left with the new bit in the LSB; the oldest bit falls off the top.
  assign w_pat_shift = PAT_W'({r_pat, in});
  assign w_win       = PAT_W'({r_shreg, in});

  // A match needs PAT_W bits received since the last restart (cnt counts the older ones).
  assign w_match = (r_cnt >= LAST) && (w_win == r_pat);

  assign out = r_out;

  // State register: all state clears asynchronously, learning restarts from bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= LEARN;
      r_pat   <= '0;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pat   <= w_pat_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Next-state: LEARN captures the pattern, DETECT slides the window and flags matches.
  always_comb begin
    w_phase_nxt = r_phase;
    w_pat_nxt   = r_pat;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = 1'b0;
    case (r_phase)
      LEARN: begin
        w_pat_nxt = w_pat_shift;
        if (r_cnt == LAST) begin
          w_phase_nxt = DETECT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DETECT: begin
        w_shreg_nxt = w_win;
        if (w_match) begin
          w_out_nxt = 1'b1;
`ifdef DYPAT_OVERLAP_EN
          // Keep the window considered full so the very next bit can complete another match.
          w_cnt_nxt = FULL;
`else
          // Restart: the next match must be built entirely from bits after this one.
          w_cnt_nxt = '0;
`endif
        end else if (r_cnt != FULL) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_phase_nxt = LEARN;
      end
    endcase
  end

endmodule

// File: tb/tb_dypat.sv
// Scoreboard bench for dypat (PAT_W=4): stimulus pushes the expected out per bit,
// a monitor pops and compares one entry after every posedge that consumed a bit.
module tb_dypat;

  localparam int PAT_W = 4;

`ifdef DYPAT_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk;
  logic rst;
  logic tb_in;
  logic tb_out;

  int checks;
  int errors;
  int pulse_cnt;

  logic  exp_q[$];
  string nm_q[$];

  dypat #(.PAT_W(PAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .in  (tb_in),
    .out (tb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive one bit, record its expected out, return at the next negedge.
  task automatic send(input logic b, input logic e, input string nm);
    tb_in = b;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  // Bits and expectations given MSB-first (first bit sent is bits[n-1]).
  task automatic run_vec(input logic [15:0] bits, input logic [15:0] exps, input int n, input string nm);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exps[i], nm);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    tb_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {15'd0, tb_out}, 16'd0);
    rst = 1'b1;
  endtask

  // Monitor: compare out against the scoreboard just after each consuming edge.
  initial begin
    logic  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, {15'd0, tb_out}, {15'd0, e});
        if (tb_out === 1'b1) pulse_cnt++;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic       fresh[$];
    logic [3:0] win;
    logic       b;
    logic       m;
    int         model_cnt;
    int         base;

    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst       = 1'b0;
    tb_in     = 1'b0;
    @(negedge clk);

    // Learn 1011: no output during learning.
    do_reset();
    chk("rst_pat", {12'd0, dut.r_pat}, 16'h0);
    run_vec(16'b1011, 16'b0000, 4, "learn_1011");
    chk("pat_1011", {12'd0, dut.r_pat}, 16'hB);
    chk("cnt_after_learn", {13'd0, dut.r_cnt}, 16'd0);

    // Single match, then a non-matching bit.
    run_vec(16'b10110, 16'b00010, 5, "single_match");

    // Learning bits never count toward a match.
    do_reset();
    run_vec(16'b1011, 16'b0000, 4, "learn_1011b");
    run_vec(16'b011, 16'b000, 3, "no_reuse");

    // Overlapping occurrences of 1011.
    do_reset();
    run_vec(16'b1011, 16'b0000, 4, "learn_1011c");
    run_vec(16'b1011011, OVL ? 16'b0001001 : 16'b0001000, 7, "overlap_1011");

    // Pattern 1111 against six ones.
    do_reset();
    run_vec(16'b1111, 16'b0000, 4, "learn_1111");
    chk("pat_1111", {12'd0, dut.r_pat}, 16'hF);
    run_vec(16'b111111, OVL ? 16'b000111 : 16'b000100, 6, "ones_1111");

    // Asynchronous reset while out is high.
    do_reset();
    run_vec(16'b1011, 16'b0000, 4, "learn_1011d");
    run_vec(16'b1011, 16'b0001, 4, "pre_reset_match");
    chk("out_before_rst", {15'd0, tb_out}, 16'd1);
    #1 rst = 1'b0;
    #1 chk("async_drop", {15'd0, tb_out}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("async_hold", {15'd0, tb_out}, 16'd0);
    rst = 1'b1;

    // Relearn 0110 and detect it.
    run_vec(16'b0110, 16'b0000, 4, "learn_0110");
    chk("pat_0110", {12'd0, dut.r_pat}, 16'h6);
    run_vec(16'b0110, 16'b0001, 4, "detect_0110");

    // Random soak against a fresh-bit history model.
    fresh.delete();
    if (OVL) begin
      fresh.push_back(1'b0); fresh.push_back(1'b1);
      fresh.push_back(1'b1); fresh.push_back(1'b0);
    end
    model_cnt = 0;
    base      = pulse_cnt;
    for (int i = 0; i < 600; i++) begin
      b = 1'($urandom_range(1, 0));
      fresh.push_back(b);
      if (fresh.size() > PAT_W) void'(fresh.pop_front());
      m = 1'b0;
      if (fresh.size() == PAT_W) begin
        win = {fresh[0], fresh[1], fresh[2], fresh[3]};
        m   = (win == 4'b0110);
      end
      if (m) begin
        model_cnt++;
        if (!OVL) fresh.delete();
      end
      send(b, m, "soak");
    end
    chk("soak_count", 16'(pulse_cnt - base), 16'(model_cnt));
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
